// File: rtl/fine_code_ctrl.sv
// Fine-code loop controller: coarse acquisition steps, then +/-1 tracking in LOCK.
// Commit-qualified decisions move a saturating 8-bit oscillator code.
module fine_code_ctrl (
  input  logic       ref_clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       commit,
  input  logic [1:0] dir,
  input  logic [7:0] init_code,
  input  logic [2:0] acq_step,
  input  logic [3:0] lock_thresh,
  output logic [7:0] osc_fine_con,
  output logic       locked,
  output logic       sat_hi,
  output logic       sat_lo,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'b00, ACQ = 2'b01, LOCK = 2'b10} state_t;

  state_t     st_q, st_d;
  logic [7:0] code_q, code_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] run_q, run_d, run_nxt;
  logic       last_up_q, last_up_d;
  logic       locked_q, sat_hi_q, sat_lo_q;

  logic       mv_up, mv_dn, mv_hold;
  logic [2:0] acq_eff;
  logic [3:0] thr_eff;
  logic [8:0] step9, up_sum, dn_diff;
  logic [7:0] moved;
  logic [4:0] hold_inc;

  assign mv_up   = commit && (dir == 2'b01);
  assign mv_dn   = commit && (dir == 2'b10);
  assign mv_hold = commit && (dir == 2'b00 || dir == 2'b11);
  assign acq_eff = (acq_step == 3'd0) ? 3'd1 : acq_step;
  assign thr_eff = (lock_thresh == 4'd0) ? 4'd1 : lock_thresh;
  assign step9   = (st_q == ACQ) ? {6'd0, acq_eff} : 9'd1;
  assign up_sum  = {1'b0, code_q} + step9;
  assign dn_diff = {1'b0, code_q} - step9;
  // borrow/carry in bit 8 means the move would leave 0..255: clamp
  assign moved   = mv_up ? (up_sum[8] ? 8'hFF : up_sum[7:0])
                         : (dn_diff[8] ? 8'h00 : dn_diff[7:0]);
  assign hold_inc = {1'b0, hold_q} + 5'd1;
  assign run_nxt  = (run_q != 2'd0 && last_up_q == mv_up) ? run_q + 2'd1 : 2'd1;

  always_comb begin
    st_d      = st_q;
    code_d    = code_q;
    hold_d    = hold_q;
    run_d     = run_q;
    last_up_d = last_up_q;
    case (st_q)
      IDLE: begin
        if (en) begin
          code_d = init_code;
          hold_d = 4'd0;
          run_d  = 2'd0;
          st_d   = ACQ;
        end
      end
      ACQ: begin
        if (!en) st_d = IDLE;
        else if (mv_up || mv_dn) begin
          code_d = moved;
          hold_d = 4'd0;
        end else if (mv_hold) begin
          if (hold_inc == {1'b0, thr_eff}) begin
            st_d   = LOCK;
            hold_d = 4'd0;
            run_d  = 2'd0;
          end else begin
            hold_d = hold_inc[3:0];
          end
        end
      end
      LOCK: begin
        if (!en) st_d = IDLE;
        else if (mv_up || mv_dn) begin
          code_d    = moved;
          last_up_d = mv_up;
          hold_d    = 4'd0;
          // third consecutive same-direction move drops back to acquisition
          if (run_nxt == 2'd3) begin
            st_d  = ACQ;
            run_d = 2'd0;
          end else begin
            run_d = run_nxt;
          end
        end else if (mv_hold) begin
          run_d = 2'd0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      code_q    <= 8'h80;
      hold_q    <= 4'd0;
      run_q     <= 2'd0;
      last_up_q <= 1'b0;
      locked_q  <= 1'b0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
    end else begin
      st_q      <= st_d;
      code_q    <= code_d;
      hold_q    <= hold_d;
      run_q     <= run_d;
      last_up_q <= last_up_d;
      locked_q  <= (st_d == LOCK);
      sat_hi_q  <= (code_d == 8'hFF);
      sat_lo_q  <= (code_d == 8'h00);
    end
  end

  assign osc_fine_con = code_q;
  assign locked       = locked_q;
  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;
  assign state        = st_q;

endmodule

// File: tb/tb_fine_code_ctrl.sv
// Directed bench for fine_code_ctrl: acquisition, lock entry/exit, saturation,
// async reset between edges and enable drop.
module tb_fine_code_ctrl;

  logic       ref_clk = 1'b0;
  logic       rst_n, en, commit;
  logic [1:0] dir;
  logic [7:0] init_code;
  logic [2:0] acq_step;
  logic [3:0] lock_thresh;
  logic [7:0] osc_fine_con;
  logic       locked, sat_hi, sat_lo;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] UP = 2'b01, DN = 2'b10, HD = 2'b00;
  localparam logic [1:0] S_IDLE = 2'b00, S_ACQ = 2'b01, S_LOCK = 2'b10;

  fine_code_ctrl dut (
    .ref_clk(ref_clk), .rst_n(rst_n), .en(en), .commit(commit), .dir(dir),
    .init_code(init_code), .acq_step(acq_step), .lock_thresh(lock_thresh),
    .osc_fine_con(osc_fine_con), .locked(locked), .sat_hi(sat_hi),
    .sat_lo(sat_lo), .state(state)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  // one-cycle commit pulse; outputs are checked just after the sampling edge
  task automatic cmt(input logic [1:0] d);
    commit = 1'b1;
    dir    = d;
    tick();
    commit = 1'b0;
    dir    = HD;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; commit = 1'b0; dir = HD;
    init_code = 8'd0; acq_step = 3'd1; lock_thresh = 4'd3;
    tick(); tick();
    chk("rst_code", osc_fine_con, 8'h80);
    chk("rst_state", state, S_IDLE);
    chk("rst_locked", locked, 0);
    chk("rst_sat", {sat_hi, sat_lo}, 0);

    rst_n = 1'b1;
    tick();
    chk("idle_hold_code", osc_fine_con, 8'h80);
    chk("idle_state", state, S_IDLE);

    // load cycle with a simultaneous commit: commit must be ignored
    init_code = 8'd100; acq_step = 3'd4; en = 1'b1;
    cmt(UP);
    chk("load_code", osc_fine_con, 100);
    chk("load_state", state, S_ACQ);

    cmt(UP); chk("acq_up1", osc_fine_con, 104);
    cmt(UP); chk("acq_up2", osc_fine_con, 108);
    cmt(UP); chk("acq_up3", osc_fine_con, 112);
    chk("acq_state", state, S_ACQ);

    // lock entry: hold, hold, up, hold, hold, hold with threshold 3
    cmt(HD); chk("le_h1", osc_fine_con, 112);
    cmt(HD); chk("le_h2_state", state, S_ACQ);
    cmt(UP); chk("le_up", osc_fine_con, 116);
    cmt(HD); cmt(HD);
    chk("le_not_yet", locked, 0);
    cmt(HD);
    chk("le_locked", locked, 1);
    chk("le_state", state, S_LOCK);
    chk("le_code", osc_fine_con, 116);

    // unlock: dn, dn, up, up, up in LOCK
    cmt(DN); chk("ul_dn1", osc_fine_con, 115);
    cmt(DN); chk("ul_dn2", osc_fine_con, 114);
    cmt(UP); chk("ul_up1", osc_fine_con, 115);
    cmt(UP); chk("ul_up2", osc_fine_con, 116);
    chk("ul_still_lock", state, S_LOCK);
    cmt(UP); chk("ul_up3", osc_fine_con, 117);
    chk("ul_state", state, S_ACQ);
    chk("ul_locked", locked, 0);

    // en drop with a simultaneous commit
    en = 1'b0;
    cmt(UP);
    chk("endrop_state", state, S_IDLE);
    chk("endrop_code", osc_fine_con, 117);
    cmt(DN);
    chk("idle_ignore", osc_fine_con, 117);

    // saturation high
    init_code = 8'd253; acq_step = 3'd7; en = 1'b1;
    tick();
    chk("sat_load", osc_fine_con, 253);
    cmt(UP); chk("sat_up", osc_fine_con, 255);
    chk("sat_hi1", sat_hi, 1);
    cmt(UP); chk("sat_up_again", osc_fine_con, 255);
    chk("sat_hi2", sat_hi, 1);
    cmt(DN); chk("sat_dn", osc_fine_con, 248);
    chk("sat_hi_clr", sat_hi, 0);

    // saturation low, then acq_step=0 acts as 1
    en = 1'b0; tick();
    init_code = 8'd3; en = 1'b1; tick();
    cmt(DN); chk("satlo_code", osc_fine_con, 0);
    chk("sat_lo1", sat_lo, 1);
    acq_step = 3'd0;
    cmt(UP); chk("step0_code", osc_fine_con, 1);
    chk("sat_lo_clr", sat_lo, 0);

    // lock_thresh=0 acts as 1: one hold locks
    lock_thresh = 4'd0;
    cmt(HD);
    chk("thr0_state", state, S_LOCK);

    // async reset pulsed between edges mid-LOCK
    init_code = 8'd200;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_code", osc_fine_con, 8'h80);
    chk("arst_state", state, S_IDLE);
    chk("arst_locked", locked, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("arst_reload", osc_fine_con, 200);
    chk("arst_acq", state, S_ACQ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
